// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
// Handshake: the master holds mem_req (and we/addr_sel) high until the slave
// raises mem_ready; the transfer completes in the cycle both are high.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP for unsupported opcodes and memory request timeouts.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  multicycle_ctrl_if.master        mem,
  input  logic [31:0]              i_instr,
  input  logic                     i_br_taken,
  output logic                     o_ir_we,
  output logic                     o_pc_we,
  output logic                     o_pc_sel,
  output logic [2:0]               o_imm_sel,
  output logic                     o_alu_src_b,
  output logic                     o_rf_we,
  output logic [1:0]               o_wb_sel,
  output logic                     o_illegal,
  output logic                     o_timeout,
  output logic [2:0]               o_state
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_R      = 3'd1;
  localparam logic [2:0] C_OPIMM  = 3'd2;
  localparam logic [2:0] C_LOAD   = 3'd3;
  localparam logic [2:0] C_STORE  = 3'd4;
  localparam logic [2:0] C_BRANCH = 3'd5;
  localparam logic [2:0] C_JAL    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [2:0]    cls_q, cls_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic          boot_done_q;
  logic [2:0]    dec_cls;
  logic          mem_req, mem_we, mem_addr_sel;
  logic          unused_instr_bits;

  assign unused_instr_bits = ^i_instr[31:7];

  function automatic logic [2:0] imm_of(input logic [2:0] cls);
    case (cls)
      C_OPIMM, C_LOAD: imm_of = 3'd1;
      C_STORE:         imm_of = 3'd2;
      C_BRANCH:        imm_of = 3'd3;
      C_JAL:           imm_of = 3'd4;
      default:         imm_of = 3'd0;
    endcase
  endfunction

  always_comb begin
    dec_cls = C_NONE;
    case (i_instr[6:0])
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_sel     = 1'b0;
    o_imm_sel    = 3'd0;
    o_alu_src_b  = 1'b0;
    o_rf_we      = 1'b0;
    o_wb_sel     = 2'd0;
    case (state_q)
      S_BOOT: begin
        cnt_d = '0;
        if (boot_done_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem.mem_ready) begin
          o_ir_we = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        o_imm_sel = imm_of(dec_cls);
        cls_d     = dec_cls;
        if (dec_cls == C_NONE) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        o_imm_sel   = imm_of(cls_q);
        o_alu_src_b = (cls_q != C_R);
        case (cls_q)
          C_BRANCH: begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_br_taken;
            state_d  = S_FETCH;
            cnt_d    = '0;
          end
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // Address operand stays selected while the memory may still be waiting.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
        o_imm_sel    = imm_of(cls_q);
        o_alu_src_b  = 1'b1;
        if (mem.mem_ready) begin
          if (cls_q == C_STORE) begin
            o_pc_we = 1'b1;
            state_d = S_FETCH;
            cnt_d   = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        o_rf_we     = 1'b1;
        o_pc_we     = 1'b1;
        o_imm_sel   = imm_of(cls_q);
        o_alu_src_b = (cls_q != C_R);
        o_pc_sel    = (cls_q == C_JAL);
        o_wb_sel    = (cls_q == C_LOAD) ? 2'd1 : (cls_q == C_JAL) ? 2'd2 : 2'd0;
        state_d     = S_FETCH;
        cnt_d       = '0;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // boot_done_q delays leaving BOOT by one edge so release is seen synchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_BOOT;
      cls_q       <= C_NONE;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      boot_done_q <= 1'b1;
    end
  end

  assign mem.mem_req      = mem_req;
  assign mem.mem_we       = mem_we;
  assign mem.mem_addr_sel = mem_addr_sel;
  assign o_illegal        = illegal_q;
  assign o_timeout        = timeout_q;
  assign o_state          = state_q;
endmodule
